// File: rtl/countdown_hex_display_pkg.sv
// Shared constants for the countdown display: active-low 7-segment codes,
// game-state codes on the shared state bus, and the display FSM encoding.
package countdown_hex_display_pkg;

    // Segment codes, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Game-state code in which the countdown stage is running
    localparam logic [3:0] ST_COUNTDOWN = 4'b1011;

    // Display FSM encoding; bit 1 set means the countdown has expired
    localparam logic [1:0] DS_IDLE    = 2'b00;
    localparam logic [1:0] DS_SHOW    = 2'b01;
    localparam logic [1:0] DS_EXPIRED = 2'b10;
    localparam logic [1:0] DS_DONE    = 2'b11;

endpackage

// File: rtl/countdown_hex_display_hex7_encode.sv
// Combinational 4-bit value to active-low 7-segment code.
// 0..9 map to their digit; anything above 9 is shown as a dash.
module hex7_encode
    import countdown_hex_display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    // Digit lookup
    always_comb begin
        case (val_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/countdown_hex_display.sv
// Two-digit display for the 10..0 countdown. Shows the live value while the
// game is in the countdown state, blinks "00" after the zero flag, then holds
// "00" and pulses blink_done once.
module countdown_hex_display
    import countdown_hex_display_pkg::*;
#(
    parameter int         CLK_HZ      = 50_000_000,
    parameter int         BLINK_HZ    = 2,
    parameter int         HOLD_BLINKS = 6,
    parameter logic [3:0] RUN_STATE   = ST_COUNTDOWN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [3:0] current_digit,
    input  logic       flag,
    output logic [6:0] hex_tens,
    output logic [6:0] hex_ones,
    output logic       expired,
    output logic       blink_done
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BW   = $clog2(HOLD_BLINKS + 2);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [BW-1:0] HOLD_M1 = BW'(HOLD_BLINKS - 1);

    logic [1:0]    fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] blinks_q, blinks_d;
    logic          phase_q, phase_d;   // 1 = "00" lit, 0 = blank
    logic          armed_q, armed_d;   // flag seen low since entering SHOW
    logic [6:0]    tens_q, tens_d, ones_q, ones_d;
    logic          exp_q, exp_d, done_q, done_d;

    logic          run;
    logic [3:0]    tens_val, ones_val;
    logic [6:0]    tens_seg, ones_seg;

    assign run = (state == RUN_STATE);

    // 10 splits into "1","0"; 11..15 pass through so both encoders show a dash
    assign tens_val = (current_digit == 4'd10) ? 4'd1 : current_digit;
    assign ones_val = (current_digit == 4'd10) ? 4'd0 : current_digit;

    hex7_encode u_tens (.val_i(tens_val), .seg_o(tens_seg));
    hex7_encode u_ones (.val_i(ones_val), .seg_o(ones_seg));

    // Next-state, blink timebase and registered-output selection
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        blinks_d = blinks_q;
        phase_d  = phase_q;
        armed_d  = armed_q;
        done_d   = 1'b0;
        if (!run) begin
            fsm_d    = DS_IDLE;
            cnt_d    = '0;
            blinks_d = '0;
            phase_d  = 1'b1;
            armed_d  = 1'b0;
        end else begin
            case (fsm_q)
                DS_IDLE: begin
                    fsm_d   = DS_SHOW;
                    armed_d = 1'b0;
                end
                DS_SHOW: begin
                    if (flag && armed_q) begin
                        fsm_d    = DS_EXPIRED;
                        cnt_d    = '0;
                        blinks_d = '0;
                        phase_d  = 1'b1;
                    end else begin
                        armed_d = armed_q | ~flag;
                    end
                end
                DS_EXPIRED: begin
                    if (HOLD_BLINKS == 0) begin
                        fsm_d  = DS_DONE;
                        done_d = 1'b1;
                    end else if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                        // an off->on edge completes one blink period
                        if (!phase_q) begin
                            if (blinks_q == HOLD_M1) begin
                                fsm_d  = DS_DONE;
                                done_d = 1'b1;
                            end else begin
                                blinks_d = blinks_q + BW'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end

        tens_d = SEG_BLANK;
        ones_d = SEG_BLANK;
        case (fsm_d)
            DS_SHOW: begin
                tens_d = (current_digit < 4'd10) ? SEG_BLANK : tens_seg;
                ones_d = ones_seg;
            end
            DS_EXPIRED: begin
                tens_d = phase_d ? SEG_0 : SEG_BLANK;
                ones_d = phase_d ? SEG_0 : SEG_BLANK;
            end
            DS_DONE: begin
                tens_d = SEG_0;
                ones_d = SEG_0;
            end
            default: ;
        endcase
        exp_d = fsm_d[1];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= DS_IDLE;
            cnt_q    <= '0;
            blinks_q <= '0;
            phase_q  <= 1'b1;
            armed_q  <= 1'b0;
            tens_q   <= SEG_BLANK;
            ones_q   <= SEG_BLANK;
            exp_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            blinks_q <= blinks_d;
            phase_q  <= phase_d;
            armed_q  <= armed_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            exp_q    <= exp_d;
            done_q   <= done_d;
        end
    end

    assign hex_tens   = tens_q;
    assign hex_ones   = ones_q;
    assign expired    = exp_q;
    assign blink_done = done_q;

endmodule
